// File: rtl/ntt_pkg.sv
// Shared types, defaults and modular-arithmetic helpers for the NTT butterfly datapath.
// The helpers work on the package-default coefficient width.
package ntt_pkg;

  localparam int DATA_W   = 13;
  localparam int MULT_LAT = 7;

  typedef enum logic {BF_CT = 1'b0, BF_GS = 1'b1} bfly_mode_t;

  // One extra bit holds the carry before the conditional correction.
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DATA_W]) d = d + {1'b0, q};
    return d[DATA_W-1:0];
  endfunction

  // Multiply by 2^-1 mod q: odd values become even by adding the (odd) modulus first.
  function automatic logic [DATA_W-1:0] mod_half(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] q);
    logic [DATA_W:0] h;
    h = {1'b0, x};
    if (x[0]) h = h + {1'b0, q};
    h = h >> 1;
    return h[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mod_mult_pipe.sv
// Pipelined modular multiplier: C = A*B mod q, exactly MULT_LAT enabled cycles after the operands.
module mod_mult_pipe #(
  parameter int DATA_W   = 13,
  parameter int MULT_LAT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] C
);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] qExt;
  logic [DATA_W-1:0]   pipe_q [MULT_LAT];

  assign prod = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
  assign qExt = {{DATA_W{1'b0}}, q};

  // Reduction happens in the first stage; the remaining stages only delay the residue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MULT_LAT; i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= DATA_W'(prod % qExt);
      for (int i = 1; i < MULT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign C = pipe_q[MULT_LAT-1];

endmodule

// File: rtl/ntt_bfly_pe.sv
// Fully pipelined radix-2 CT/GS butterfly with optional halving, one sample per cycle.
// The multiplier sits at the same pipeline position for both modes, so mixed-mode streams never collide.
module ntt_bfly_pe
  import ntt_pkg::*;
#(
  parameter int DATA_W   = ntt_pkg::DATA_W,
  parameter int MULT_LAT = ntt_pkg::MULT_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] q,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic              mode_i,
  input  logic              half_i,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o
);

  logic [DATA_W-1:0] a_q, b_q, w_q, sum_q, diff_q;
  bfly_mode_t        mode_q;
  logic              half_q, valid_q;
  logic [DATA_W-1:0] sum_d, diff_d;

  logic [DATA_W-1:0] aDly_q    [MULT_LAT];
  logic [DATA_W-1:0] sumDly_q  [MULT_LAT];
  bfly_mode_t        modeDly_q [MULT_LAT];
  logic              halfDly_q [MULT_LAT];
  logic              validDly_q[MULT_LAT];

  logic [DATA_W-1:0] multA, prod;
  logic              multEn;
  logic [DATA_W-1:0] aOut_d, bOut_d, aOut_q, bOut_q;
  logic              validOut_q;

  assign sum_d  = mod_add(a_i, b_i, q);
  assign diff_d = mod_sub(a_i, b_i, q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      mode_q  <= BF_CT;
      half_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      a_q     <= a_i;
      b_q     <= b_i;
      w_q     <= w_i;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      mode_q  <= bfly_mode_t'(mode_i);
      half_q  <= half_i;
      valid_q <= in_valid;
    end
  end

  assign multA  = (mode_q == BF_GS) ? diff_q : b_q;
  assign multEn = ~stall;

  mod_mult_pipe #(.DATA_W(DATA_W), .MULT_LAT(MULT_LAT)) u_mult (
    .clk   (clk),
    .reset (reset),
    .en    (multEn),
    .A     (multA),
    .B     (w_q),
    .q     (q),
    .C     (prod)
  );

  // Side-band fields ride alongside the multiplier so they meet its product at the final stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        aDly_q[i]     <= '0;
        sumDly_q[i]   <= '0;
        modeDly_q[i]  <= BF_CT;
        halfDly_q[i]  <= 1'b0;
        validDly_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      aDly_q[0]     <= a_q;
      sumDly_q[0]   <= sum_q;
      modeDly_q[0]  <= mode_q;
      halfDly_q[0]  <= half_q;
      validDly_q[0] <= valid_q;
      for (int i = 1; i < MULT_LAT; i++) begin
        aDly_q[i]     <= aDly_q[i-1];
        sumDly_q[i]   <= sumDly_q[i-1];
        modeDly_q[i]  <= modeDly_q[i-1];
        halfDly_q[i]  <= halfDly_q[i-1];
        validDly_q[i] <= validDly_q[i-1];
      end
    end
  end

  always_comb begin
    aOut_d = sumDly_q[MULT_LAT-1];
    bOut_d = prod;
    if (modeDly_q[MULT_LAT-1] == BF_CT) begin
      aOut_d = mod_add(aDly_q[MULT_LAT-1], prod, q);
      bOut_d = mod_sub(aDly_q[MULT_LAT-1], prod, q);
    end
    if (halfDly_q[MULT_LAT-1]) begin
      aOut_d = mod_half(aOut_d, q);
      bOut_d = mod_half(bOut_d, q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aOut_q     <= '0;
      bOut_q     <= '0;
      validOut_q <= 1'b0;
    end else if (!stall) begin
      aOut_q     <= aOut_d;
      bOut_q     <= bOut_d;
      validOut_q <= validDly_q[MULT_LAT-1];
    end
  end

  assign a_o       = aOut_q;
  assign b_o       = bOut_q;
  assign out_valid = validOut_q;

endmodule

// File: tb/tb_ntt_bfly_pe.sv
// Directed bench for ntt_bfly_pe at q = 7681, DATA_W = 13, MULT_LAT = 7 (results 8 edges after capture).
module tb_ntt_bfly_pe;

  localparam int DW  = 13;
  localparam int LAT = 7;
  localparam int QV  = 7681;

  logic          clk;
  logic          reset;
  logic [DW-1:0] q;
  logic          in_valid;
  logic [DW-1:0] a_i, b_i, w_i;
  logic          mode_i, half_i, stall;
  logic          out_valid;
  logic [DW-1:0] a_o, b_o;

  int testsRun    = 0;
  int testsFailed = 0;

  ntt_bfly_pe #(.DATA_W(DW), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .in_valid  (in_valid),
    .a_i       (a_i),
    .b_i       (b_i),
    .w_i       (w_i),
    .mode_i    (mode_i),
    .half_i    (half_i),
    .stall     (stall),
    .out_valid (out_valid),
    .a_o       (a_o),
    .b_o       (b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference butterfly written directly from the modular definitions.
  function automatic void refModel(input int a, input int b, input int w, input bit m, input bit h,
                                   output int ea, output int eb);
    longint p;
    if (!m) begin
      p  = (longint'(w) * longint'(b)) % QV;
      ea = int'((a + p) % QV);
      eb = int'((a - p + QV) % QV);
    end else begin
      ea = (a + b) % QV;
      eb = int'((longint'((a - b + QV) % QV) * longint'(w)) % QV);
    end
    if (h) begin
      ea = (ea % 2 == 1) ? (ea + QV) / 2 : ea / 2;
      eb = (eb % 2 == 1) ? (eb + QV) / 2 : eb / 2;
    end
  endfunction

  // Drive one cycle of inputs, then step past the capturing edge.
  task automatic applyStimulus(input bit v, input int a, input int b, input int w,
                               input bit m, input bit h);
    in_valid = v;
    a_i      = a[DW-1:0];
    b_i      = b[DW-1:0];
    w_i      = w[DW-1:0];
    mode_i   = m;
    half_i   = h;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Single isolated sample: measures latency and checks both results.
  task automatic runOne(input string tag, input int a, input int b, input int w,
                        input bit m, input bit h, input int ea, input int eb);
    int lat;
    applyStimulus(1, a, b, w, m, h);
    lat = 0;
    while (!out_valid && lat < 20) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, LAT + 1);
    checkOutput({tag, "_a"}, int'(a_o), ea);
    checkOutput({tag, "_b"}, int'(b_o), eb);
    idle(3);
  endtask

  bit hv [128];
  int ha [128];
  int hb [128];
  int sa [5];
  int sb [5];
  int step, issued, lastValid, ra, rb, rw, ea, eb, lat;
  bit rv, rm, rh;

  initial begin
    reset = 1'b1;
    q = DW'(QV);
    stall = 1'b0;
    in_valid = 1'b0;
    a_i = '0; b_i = '0; w_i = '0; mode_i = 1'b0; half_i = 1'b0;
    #1;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_a", int'(a_o), 0);
    checkOutput("reset_b", int'(b_o), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Directed vectors with hand-computed results.
    runOne("ct_basic", 100, 3, 2, 0, 0, 106, 94);
    runOne("gs_wrap", 5, 10, 3, 1, 0, 15, 7666);
    runOne("gs_half", 5, 10, 3, 1, 1, 3848, 3833);
    runOne("ct_wrap_hi", 7680, 1, 1, 0, 0, 0, 7679);
    runOne("ct_wrap_sq", 0, 7680, 7680, 0, 0, 1, 7680);
    idle(8);

    // Streaming: random operands, alternating mode/half, random bubbles.
    step = 0; issued = 0; lastValid = 0;
    while (step < 120) begin
      rv = (issued < 32) && ($urandom_range(0, 3) != 0);
      ra = int'($urandom_range(0, QV - 1));
      rb = int'($urandom_range(0, QV - 1));
      rw = int'($urandom_range(0, QV - 1));
      rm = issued[0];
      rh = issued[1];
      hv[step] = rv;
      if (rv) begin
        refModel(ra, rb, rw, rm, rh, ea, eb);
        ha[step] = ea;
        hb[step] = eb;
        issued++;
        lastValid = step;
      end
      applyStimulus(rv, ra, rb, rw, rm, rh);
      if (step >= LAT + 1) begin
        checkOutput("stream_valid", int'(out_valid), int'(hv[step-LAT-1]));
        if (hv[step-LAT-1]) begin
          checkOutput("stream_a", int'(a_o), ha[step-LAT-1]);
          checkOutput("stream_b", int'(b_o), hb[step-LAT-1]);
        end
      end else begin
        checkOutput("stream_valid_head", int'(out_valid), 0);
      end
      step++;
      if (issued == 32 && step > lastValid + LAT + 1) break;
    end
    checkOutput("stream_issued", issued, 32);
    idle(4);

    // Stall: 5 samples, first reaches the output, then 3 stalled cycles with 4 in flight.
    for (int k = 0; k < 5; k++) begin
      refModel(1000 + 37 * k, 2000 + 11 * k, 3 + k, k[0], k[1], ea, eb);
      sa[k] = ea;
      sb[k] = eb;
      applyStimulus(1, 1000 + 37 * k, 2000 + 11 * k, 3 + k, k[0], k[1]);
    end
    for (int e = 5; e <= 7; e++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("stall_pre_valid", int'(out_valid), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall_s0_valid", int'(out_valid), 1);
    checkOutput("stall_s0_a", int'(a_o), sa[0]);
    stall = 1'b1;
    for (int e = 9; e <= 11; e++) begin
      applyStimulus(1, 1, 1, 1, 0, 0);
      checkOutput("stall_hold_valid", int'(out_valid), 1);
      checkOutput("stall_hold_a", int'(a_o), sa[0]);
      checkOutput("stall_hold_b", int'(b_o), sb[0]);
    end
    stall = 1'b0;
    for (int e = 12; e <= 15; e++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("stall_post_valid", int'(out_valid), 1);
      checkOutput("stall_post_a", int'(a_o), sa[e-11]);
      checkOutput("stall_post_b", int'(b_o), sb[e-11]);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall_tail_valid", int'(out_valid), 0);
    idle(4);

    // Reset mid-stream: one sample at the output, five more in flight.
    applyStimulus(1, 100, 3, 2, 0, 0);
    idle(3);
    for (int k = 0; k < 5; k++) applyStimulus(1, 200 + k, 300 + k, 5, 0, 0);
    checkOutput("rst_pre_valid", int'(out_valid), 1);
    checkOutput("rst_pre_a", int'(a_o), 106);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", int'(out_valid), 0);
    checkOutput("rst_async_a", int'(a_o), 0);
    checkOutput("rst_async_b", int'(b_o), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst_drain_valid", int'(out_valid), 0);
    end
    applyStimulus(1, 5, 10, 3, 1, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      lat++;
    end
    checkOutput("rst_after_lat", lat, LAT + 1);
    checkOutput("rst_after_a", int'(a_o), 15);
    checkOutput("rst_after_b", int'(b_o), 7666);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
